// File: rtl/aes_block_loader_if.sv
// Word-stream and block-issue bundle for aes_block_loader.
// Ports: wordIn/wordValid/wordIsKey/wordReady in, out/keyOut/validOut issue.
interface aes_block_loader_if;
    logic [31:0]  wordIn;
    logic         wordValid;
    logic         wordIsKey;
    logic         wordReady;
    logic [127:0] out;
    logic [127:0] keyOut;
    logic         validOut;

    modport slave (
        input  wordIn,
        input  wordValid,
        input  wordIsKey,
        output wordReady,
        output out,
        output keyOut,
        output validOut
    );

    modport master (
        output wordIn,
        output wordValid,
        output wordIsKey,
        input  wordReady,
        input  out,
        input  keyOut,
        input  validOut
    );
endinterface

// File: rtl/aes_block_loader.sv
// Assembles 32-bit words into 128-bit AES keys and plaintext blocks.
// Ports: clk, rst (async high), bus (slave), keyValid, error, blockCount.
module aes_block_loader #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    aes_block_loader_if.slave  bus,
    output logic               keyValid,
    output logic               error,
    output logic [COUNT_W-1:0] blockCount
);

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        DATA,
        ISSUE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [127:0]         stage_q, stage_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         data_q, data_d;
    logic [127:0]         out_q, out_d;
    logic [127:0]         kout_q, kout_d;
    logic                 kv_q, kv_d;
    logic                 err_q, err_d;
    logic [COUNT_W-1:0]   bc_q, bc_d;
    logic                 acc;

    // Slot 0 is the MSB word (AES byte 0 first).
    function automatic logic [127:0] place(
        input logic [127:0] v,
        input logic [1:0]   idx,
        input logic [31:0]  w
    );
        logic [127:0] r;
        r = v;
        unique case (idx)
            2'd0: r[127:96] = w;
            2'd1: r[95:64]  = w;
            2'd2: r[63:32]  = w;
            2'd3: r[31:0]   = w;
        endcase
        return r;
    endfunction

    // Ready and valid are pure state decodes, so reset drops them at once.
    assign bus.wordReady = (state_q != ISSUE);
    assign bus.validOut  = (state_q == ISSUE);
    assign bus.out       = out_q;
    assign bus.keyOut    = kout_q;
    assign keyValid      = kv_q;
    assign error         = err_q;
    assign blockCount    = bc_q;

    assign acc = bus.wordValid && bus.wordReady;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        key_d   = key_q;
        data_d  = data_q;
        out_d   = out_q;
        kout_d  = kout_q;
        kv_d    = kv_q;
        err_d   = err_q;
        bc_d    = bc_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (bus.wordIsKey) begin
                        stage_d = place(stage_q, 2'd0, bus.wordIn);
                        cnt_d   = 2'd1;
                        state_d = KEY;
                    end else if (kv_q) begin
                        data_d  = place(data_q, 2'd0, bus.wordIn);
                        cnt_d   = 2'd1;
                        state_d = DATA;
                    end else begin
                        // Plaintext with no key to pair it with.
                        err_d = 1'b1;
                    end
                end
            end
            KEY: begin
                if (acc) begin
                    if (!bus.wordIsKey) begin
                        err_d   = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        stage_d = place(stage_q, cnt_q, bus.wordIn);
                        if (cnt_q == 2'd3) begin
                            key_d   = stage_d;
                            kv_d    = 1'b1;
                            cnt_d   = 2'd0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    if (bus.wordIsKey) begin
                        err_d   = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        data_d = place(data_q, cnt_q, bus.wordIn);
                        if (cnt_q == 2'd3) begin
                            // Capture now so out is valid in ISSUE.
                            out_d   = data_d;
                            kout_d  = key_q;
                            cnt_d   = 2'd0;
                            state_d = ISSUE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                bc_d    = bc_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            stage_q <= '0;
            key_q   <= '0;
            data_q  <= '0;
            out_q   <= '0;
            kout_q  <= '0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            key_q   <= key_d;
            data_q  <= data_d;
            out_q   <= out_d;
            kout_q  <= kout_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
            bc_q    <= bc_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader with directed key/data vectors.
// Monitor pops expected blocks on each validOut pulse.
module tb_aes_block_loader;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] D3 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] D4 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] D5 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] D6 = 128'hf69f2445df4f9b17ad2b417be66c3710;

    typedef struct {
        logic [127:0] d;
        logic [127:0] k;
        logic [1:0]   c;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       keyValid;
    logic       error;
    logic [1:0] blockCount;

    aes_block_loader_if bus ();

    aes_block_loader #(.COUNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .keyValid   (keyValid),
        .error      (error),
        .blockCount (blockCount)
    );

    int   checks = 0;
    int   errors = 0;
    int   nblk   = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic [127:0] k);
        exp_t e;
        e.d = d;
        e.k = k;
        e.c = 2'(nblk);
        sb.push_back(e);
        nblk++;
    endtask

    task automatic send(input logic [31:0] w, input logic k,
                        input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        while (!bus.wordReady && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.wordReady) begin
            chk("ready_timeout", {127'd0, bus.wordReady}, 128'd1);
        end
        bus.wordValid = 1'b1;
        bus.wordIn    = w;
        bus.wordIsKey = k;
        @(posedge clk);
        #1;
        bus.wordValid = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] v, input logic k,
                            input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send(v[127-32*i -: 32], k, $urandom_range(0, maxgap));
        end
    endtask

    task automatic do_reset();
        bus.wordValid = 1'b0;
        rst = 1'b1;
        sb.delete();
        nblk = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.validOut) begin
                chk("no_back_to_back", {127'd0, prev_v}, 128'd0);
                chk("ready_in_issue", {127'd0, bus.wordReady}, 128'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: out %h expected none",
                             bus.out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("block_out", bus.out, mon_e.d);
                    chk("block_key", bus.keyOut, mon_e.k);
                    chk("count_in_issue", {126'd0, blockCount},
                        {126'd0, mon_e.c});
                end
            end
            prev_v = bus.validOut;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected earlier finish", $time);
        $fatal(1);
    end

    initial begin
        bus.wordValid = 1'b0;
        bus.wordIn    = '0;
        bus.wordIsKey = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ready", {127'd0, bus.wordReady}, 128'd1);
        chk("rst_valid", {127'd0, bus.validOut}, 128'd0);
        chk("rst_keyvalid", {127'd0, keyValid}, 128'd0);
        chk("rst_error", {127'd0, error}, 128'd0);
        chk("rst_count", {126'd0, blockCount}, 128'd0);
        chk("rst_out", bus.out, 128'd0);
        chk("rst_keyout", bus.keyOut, 128'd0);
        do_reset();

        // Key load then block.
        for (int i = 0; i < 3; i++) send(K1[127-32*i -: 32], 1'b1, 0);
        chk("kv_before_4th", {127'd0, keyValid}, 128'd0);
        send(K1[31:0], 1'b1, 0);
        chk("kv_after_4th", {127'd0, keyValid}, 128'd1);
        push(D1, K1);
        send_blk(D1, 1'b0, 0);
        chk("valid_latency", {127'd0, bus.validOut}, 128'd1);
        @(negedge clk);
        @(negedge clk);
        chk("count_after_1", {126'd0, blockCount}, 128'd1);

        // Data with no key.
        do_reset();
        send(D2[127:96], 1'b0, 0);
        chk("nokey_error", {127'd0, error}, 128'd1);
        chk("nokey_kv", {127'd0, keyValid}, 128'd0);
        chk("nokey_ready", {127'd0, bus.wordReady}, 128'd1);
        send_blk(K1, 1'b1, 0);
        push(D2, K1);
        send_blk(D2, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("error_sticky", {127'd0, error}, 128'd1);

        // Kind switch mid-group, then gaps, key swap, wrap.
        do_reset();
        send_blk(K1, 1'b1, 0);
        chk("switch_pre_err", {127'd0, error}, 128'd0);
        send(D6[127:96], 1'b0, 0);
        send(D6[95:64], 1'b0, 0);
        send(K2[127:96], 1'b1, 0);
        chk("switch_error", {127'd0, error}, 128'd1);
        chk("switch_kv", {127'd0, keyValid}, 128'd1);
        push(D3, K1);
        send_blk(D3, 1'b0, 0);
        push(D4, K1);
        send_blk(D4, 1'b0, 3);
        send_blk(K2, 1'b1, 3);
        push(D5, K2);
        send_blk(D5, 1'b0, 3);
        push(D6, K2);
        send_blk(D6, 1'b0, 0);
        push(D1, K2);
        send_blk(D1, 1'b0, 2);
        repeat (3) @(negedge clk);
        chk("wrap_count", {126'd0, blockCount}, 128'd1);

        // Reset while DATA holds three words.
        do_reset();
        send_blk(K1, 1'b1, 0);
        for (int i = 0; i < 3; i++) send(D2[127-32*i -: 32], 1'b0, 0);
        rst = 1'b1;
        #1;
        chk("rstd_kv", {127'd0, keyValid}, 128'd0);
        chk("rstd_ready", {127'd0, bus.wordReady}, 128'd1);
        chk("rstd_keyout", bus.keyOut, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        nblk = 0;
        send(D2[31:0], 1'b0, 0);
        chk("rstd_error", {127'd0, error}, 128'd1);
        repeat (4) @(negedge clk);

        // Reset during the ISSUE pulse.
        do_reset();
        send_blk(K2, 1'b1, 0);
        for (int i = 0; i < 3; i++) send(D3[127-32*i -: 32], 1'b0, 0);
        send(D3[31:0], 1'b0, 0);
        chk("issue_pulse", {127'd0, bus.validOut}, 128'd1);
        rst = 1'b1;
        #1;
        chk("rsti_valid", {127'd0, bus.validOut}, 128'd0);
        chk("rsti_out", bus.out, 128'd0);
        chk("rsti_keyout", bus.keyOut, 128'd0);
        chk("rsti_count", {126'd0, blockCount}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        nblk = 0;
        repeat (6) @(negedge clk);

        chk("sb_empty", 128'(sb.size()), 128'd0);
        chk("final_count", {126'd0, blockCount}, 128'(2'(nblk)));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Upstream feeder for the `ENCRYPT` pipeline. It accepts a 32-bit word stream under a valid/ready handshake and assembles 128-bit keys and 128-bit plaintext blocks. For each completed block it issues a single-cycle `validOut` pulse carrying the block and the currently committed key, which drive `in`/`key`/`validIn` of the encrypt pipeline. It also detects protocol errors, tracks key presence and counts issued blocks.

## Interface
- `COUNT_W`, default 16: width of the issued-block counter.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wordIn`  in  32  next key or data word.
- `wordValid`  in  1  `wordIn` is valid this cycle.
- `wordIsKey`  in  1  1 = word belongs to a key, 0 = plaintext word; sampled with `wordIn`.
- `wordReady`  out  1  loader accepts a word this cycle.
- `out`  out  128  assembled plaintext block.
- `keyOut`  out  128  committed key issued with the block.
- `validOut`  out  1  one-cycle pulse: `out` and `keyOut` are valid.
- `keyValid`  out  1  a complete key has been committed since reset.
- `error`  out  1  sticky protocol-error flag.
- `blockCount`  out  COUNT_W  number of blocks issued, modulo 2^COUNT_W.

## Operation
- A word is accepted when `wordValid && wordReady` is high at a rising edge.
- Word order is big-endian: the first accepted word of a group goes to bits [127:96] and the fourth to [31:0]. This matches AES byte 0 in the MSB.
- States:
  - `IDLE`: no partial group held.
  - `KEY`: 1–3 key words held in a staging register.
  - `DATA`: 1–3 data words held.
  - `ISSUE`: output pulse cycle.
- A 2-bit word counter indexes the slot within the group.
- Transitions from `IDLE`:
  - Accepted word with `wordIsKey=1`: write it to staging [127:96] and go to `KEY` with count 1.
  - Accepted word with `wordIsKey=0` while `keyValid=1`: write it to data [127:96] and go to `DATA`.
  - Accepted word with `wordIsKey=0` while `keyValid=0`: drop the word, set `error`, stay in `IDLE`.
- Transitions from `KEY`:
  - Each accepted key word fills the next slot.
  - On the 4th word, copy staging into the committed key, set `keyValid`, and return to `IDLE`.
  - An accepted word with `wordIsKey=0`: drop the word, discard the partial key (committed key unchanged), set `error`, go to `IDLE`.
- Transitions from `DATA`:
  - Each accepted data word fills the next slot.
  - On the 4th word, go to `ISSUE`.
  - An accepted word with `wordIsKey=1`: drop the word, discard the partial block, set `error`, go to `IDLE`.
- `ISSUE` (one cycle):
  - `wordReady=0` and `validOut=1`.
  - `out` = assembled block; `keyOut` = committed key.
  - `blockCount` increments at the end of the cycle, wrapping from all-ones to 0.
  - Next state is `IDLE`.
- A key commit while no block is in `DATA` only affects later blocks. A block issued from `ISSUE` always carries the key committed before its first data word. Key loading is legal only from `IDLE`, so this holds by construction.
- `error` is cleared only by `rst`. Operation continues normally after an error.
- `out` and `keyOut` are registered. They hold their last values outside `ISSUE` and are don't-care when `validOut=0`.

## Timing
- Reset values:
  - State `IDLE`, word counter 0.
  - `wordReady=1`, `validOut=0`, `keyValid=0`, `error=0`, `blockCount=0`.
  - `out`, `keyOut`, staging and committed key registers all 0.
- `wordReady` is 1 in every state except `ISSUE`. It is a registered or state-decoded output, not combinational on `wordValid`.
- Latency: if the 4th data word is accepted at edge N, `validOut` is high for the cycle between edges N and N+1. It is never high for two consecutive cycles.
- Throughput: at most one block per 5 cycles (4 words plus the `ISSUE` bubble). Key load takes 4 cycles with no bubble.
- `rst` asserted mid-group (any state, including `ISSUE`):
  - The partial group and committed key are lost immediately.
  - `validOut` drops asynchronously.
  - After release, the first word is treated as in `IDLE` with `keyValid=0`.
- `wordValid=0` cycles inside a group are allowed. State and partial data hold indefinitely.

## Test plan
- Key load then block:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f (`wordIsKey=1`), then data words 00112233, 44556677, 8899aabb, ccddeeff back-to-back.
  - Response: `keyValid` rises after the 4th key word. `validOut` pulses once, one cycle after the 8th word, with `out`=00112233445566778899aabbccddeeff and `keyOut`=000102030405060708090a0b0c0d0e0f. `wordReady=0` in that cycle. `blockCount`=1.
- Data with no key after reset:
  - Stimulus: one data word.
  - Response: `error`=1, no `validOut`, state remains `IDLE`. A subsequent full key then block still issues correctly with `error` staying 1.
- Kind switch mid-group:
  - Stimulus: 2 data words, then 1 key word.
  - Response: `error`=1, partial block discarded, no `validOut`, committed key unchanged. The next 4 data words issue a block with the old key.
- Gaps and key replacement:
  - Stimulus: data words separated by random `wordValid=0` gaps, then a new key, then a block.
  - Response: each block carries exactly the key committed before its first word.
- Counter wrap:
  - Stimulus: `COUNT_W`=2, issue 5 blocks.
  - Response: `blockCount` sequence is 1, 2, 3, 0, 1.
- Reset mid-operation:
  - Stimulus: assert `rst` during `DATA` (count 3) and separately during `ISSUE`.
  - Response: all outputs immediately take their reset values and no stale block is issued after release.
